// File: rtl/sra_datapath.sv
// Arithmetic right-shift datapath slaved to the SRA controller state code.
// Optional build macro SRA_CLAMP_EN clamps oversized shift amounts to WIDTH-1.
module sra_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               state,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [$clog2(WIDTH):0]   shamt_in,
  output logic [WIDTH-1:0]         result,
  output logic                     done,
  output logic                     busy
);

  localparam int SW = $clog2(WIDTH);

  logic [WIDTH-1:0] op_a;
  logic [SW-1:0]    cnt;
  logic [SW-1:0]    cnt_load;

`ifdef SRA_CLAMP_EN
  localparam logic [SW:0]   WIDTH_C = (SW+1)'(WIDTH);
  localparam logic [SW-1:0] CNT_MAX = SW'(WIDTH - 1);

  // Oversized amounts saturate to a full sign fill instead of wrapping.
  always_comb begin
    cnt_load = shamt_in[SW-1:0];
    if (shamt_in >= WIDTH_C) cnt_load = CNT_MAX;
  end
`else
  logic unused_shamt_msb;

  assign unused_shamt_msb = shamt_in[SW];
  assign cnt_load         = shamt_in[SW-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        4'd0, 4'd14, 4'd15: busy <= 1'b0;
        4'd1: begin
          op_a <= data_in;
          done <= 1'b0;
          busy <= 1'b1;
        end
        4'd2: cnt <= cnt_load;
        4'd7: begin
          if (cnt == '0 && !done) begin
            result <= op_a;
            done   <= 1'b1;
            busy   <= 1'b0;
          end
        end
        4'd8: begin
          if (cnt != '0) op_a <= {op_a[WIDTH-1], op_a[WIDTH-1:1]};
        end
        4'd9: begin
          // Gated so the count parks at zero and later loop passes are inert.
          if (cnt != '0) cnt <= cnt - SW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sra_datapath.sv
// Scoreboard bench for sra_datapath: a controller model drives state codes,
// expected results are queued at issue and checked when done rises.
module tb_sra_datapath;

  localparam int WIDTH = 8;
  localparam int SW    = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       state = 4'd0;
  logic [WIDTH-1:0] data_in = '0;
  logic [SW:0]      shamt_in = '0;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  sra_datapath #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .data_in  (data_in),
    .shamt_in (shamt_in),
    .result   (result),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               lat;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  int start_edge = 0;
  logic done_q = 1'b0;
  logic [WIDTH-1:0] prev_result = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Apply a state code for one clock; returns at the following negedge.
  task automatic tick(input logic [3:0] s);
    state = s;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst && state == 4'd1) start_edge = edge_cnt;
  end

  always @(negedge clk) begin
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("busy_at_done", 32'(busy), 32'(0));
        check("latency_edges", 32'(edge_cnt - start_edge), 32'(e.lat));
      end
    end
    done_q = done;
  end

  // One full operation: load, settle, then k+2 loop passes (one spare pass
  // after done to show further passes are inert). ill_pass >= 0 inserts
  // illegal codes 14/15/14 before that pass.
  task automatic run_op(input logic [WIDTH-1:0] d, input logic [SW:0] sh,
                        input int k, input logic [WIDTH-1:0] res, input int ill_pass);
    exp_t e;
    e.res = res;
    e.lat = 6 + 7 * k + ((ill_pass >= 0 && ill_pass <= k) ? 3 : 0);
    exp_q.push_back(e);
    data_in  = d;
    shamt_in = sh;
    tick(4'd1);
    check("busy_after_load", 32'(busy), 32'(1));
    check("done_after_load", 32'(done), 32'(0));
    check("result_held", 32'(result), 32'(prev_result));
    for (int s = 2; s <= 6; s++) tick(4'(s));
    for (int p = 0; p < k + 2; p++) begin
      if (p == ill_pass) begin
        tick(4'd14);
        tick(4'd15);
        tick(4'd14);
        check("illegal_busy", 32'(busy), 32'(0));
        check("illegal_done", 32'(done), 32'(0));
        check("illegal_result", 32'(result), 32'(prev_result));
      end
      for (int s = 7; s <= 13; s++) tick(4'(s));
    end
    check("result_after_loop", 32'(result), 32'(res));
    check("done_after_loop", 32'(done), 32'(1));
    prev_result = res;
    tick(4'd0);
    tick(4'd0);
  endtask

  initial begin
    // Reset must win over a simultaneous load code.
    rst     = 1'b1;
    data_in = 8'h55;
    tick(4'd1);
    rst = 1'b0;
    check("reset_result", 32'(result), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    tick(4'd0);

    run_op(8'h96, 4'd3, 3, 8'hF2, -1);
    run_op(8'h5C, 4'd2, 2, 8'h17, -1);
    run_op(8'h80, 4'd0, 0, 8'h80, -1);
`ifdef SRA_CLAMP_EN
    run_op(8'h96, 4'd12, 7, 8'hFF, -1);
`else
    run_op(8'h96, 4'd12, 4, 8'hF9, -1);
`endif
    run_op(8'h96, 4'd3, 3, 8'hF2, 2);

    // Restart mid-operation after one shift pass of 0x96 >> 3.
    data_in  = 8'h96;
    shamt_in = 4'd3;
    tick(4'd1);
    check("restart_done_drops", 32'(done), 32'(0));
    for (int s = 2; s <= 13; s++) tick(4'(s));
    check("restart_busy_mid", 32'(busy), 32'(1));
    run_op(8'h40, 4'd1, 1, 8'h20, -1);

    // Reset in the middle of an operation.
    data_in  = 8'h96;
    shamt_in = 4'd3;
    for (int s = 1; s <= 9; s++) tick(4'(s));
    rst = 1'b1;
    tick(4'd9);
    rst = 1'b0;
    check("midrst_result", 32'(result), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    prev_result = '0;
    tick(4'd0);

    run_op(8'h7F, 4'd1, 1, 8'h3F, -1);

    tick(4'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
